shift_seq: RTL and testbench

- Multi-cycle shift execution unit for the RV64 integer pipeline.
- Applies one barrel-shifter stage per clock (stage i shifts by 2^i), giving fixed-latency SLL/SRL/SRA plus the W variants.
- Sits between issue and writeback with valid/ready handshakes on both sides.
- Left shifts reuse the right-shift datapath by bit-reversing the operand before and after shifting.

---
 rtl/shift_seq.sv | 158 +++++++++++++++
 tb/tb_shift_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/shift_seq.sv
// Multi-cycle RV64 shift unit: SLL/SRL/SRA (+W) using one barrel stage (2^i) per clock.
// Latency: K = log2(N) cycles from accept to out_valid; one op per K+2 cycles.
// Backpressure: in_ready low outside IDLE; result/out_valid held while out_ready is low.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_ready      request handshake (op, word, operand, shamt sampled on accept)
//   out_valid/out_ready    result handshake (result)
//   busy                   unit is not IDLE
module shift_seq #(
  parameter int N = 64,
  localparam int K = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic         word,
  input  logic [N-1:0] operand,
  input  logic [K-1:0] shamt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0]   OP_SLL   = 2'b00;
  localparam logic [1:0]   OP_SRA   = 2'b10;
  localparam logic [1:0]   OP_RSV   = 2'b11;
  localparam logic [K-1:0] CNT_LAST = K'(K - 1);

  state_t         state_q, state_d;
  logic [K-1:0]   cnt_q, cnt_d;
  logic [N-1:0]   work_q, work_d;
  logic           fill_q, fill_d;
  logic [1:0]     op_q, op_d;
  logic           word_q, word_d;
  logic [K-1:0]   shamt_q, shamt_d;
  logic [N-1:0]   result_q, result_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;

  function automatic logic [N-1:0] bit_rev(input logic [N-1:0] v);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v[N-1-i];
    return r;
  endfunction

  // One barrel stage: shift by 2^cnt, filling with fill_q from the top.
  logic signed [N:0] stage_ext;
  assign stage_ext = $signed({fill_q, work_q}) >>> (1 << cnt_q);

  always_comb begin
    logic         word_eff;
    logic [K-1:0] shamt_eff;
    logic [N-1:0] pre;
    logic [N-1:0] post;

    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    fill_d    = fill_q;
    op_d      = op_q;
    word_d    = word_q;
    shamt_d   = shamt_q;
    result_d  = result_q;

    // W variants only exist on a 64-bit datapath; they mask shamt[5].
    word_eff  = word && (N == 64);
    shamt_eff = shamt;
    if (word_eff) shamt_eff[K-1] = 1'b0;

    pre = operand;
    if (word_eff) begin
      for (int i = 32; i < N; i++) pre[i] = (op == OP_SRA) ? operand[31] : 1'b0;
    end

    post = '0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          // Left shifts run through the right-shift path on a reversed operand.
          work_d  = (op == OP_SLL) ? bit_rev(pre) : pre;
          fill_d  = (op == OP_SRA) ? pre[N-1] : 1'b0;
          op_d    = op;
          word_d  = word_eff;
          shamt_d = shamt_eff;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shamt_q[cnt_q] && (op_q != OP_RSV)) work_d = stage_ext[N-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
          post    = (op_q == OP_SLL) ? bit_rev(work_d) : work_d;
          if (word_q) begin
            for (int i = 32; i < N; i++) post[i] = post[31];
          end
          result_d = post;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d  = IDLE;
          result_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      fill_q      <= 1'b0;
      op_q        <= '0;
      word_q      <= 1'b0;
      shamt_q     <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      fill_q      <= fill_d;
      op_q        <= op_d;
      word_q      <= word_d;
      shamt_q     <= shamt_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Outputs read as zero for as long as reset is held.
  assign in_ready  = in_ready_q & rst_n;
  assign out_valid = out_valid_q & rst_n;
  assign busy      = busy_q & rst_n;
  assign result    = rst_n ? result_q : '0;

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq (N=64): ops, W variants, backpressure, reset abort, throughput.
// Latency: checks exact K=6 accept-to-valid latency on every transaction.
// Backpressure: exercises out_ready=0 hold with a competing request pending.
module tb_shift_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic        word;
  logic [63:0] operand;
  logic [5:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  shift_seq #(.N(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .operand(operand), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    check("wait_in_ready", 64'(in_ready), 64'd1);
  endtask

  // Counts cycles after the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic w,
                        input logic [63:0] a, input logic [5:0] s, input logic [63:0] exp);
    int lat;
    wait_ready();
    in_valid = 1'b1; op = o; word = w; operand = a; shamt = s;
    step();
    in_valid = 1'b0; operand = '0; shamt = '0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_res_shift"}, result, 64'd0);
    wait_valid(lat);
    check({tag, "_latency"}, 64'(lat), 64'd6);
    check({tag, "_result"}, result, exp);
    step();
    check({tag, "_retired"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    int acc [3];
    int nacc;

    rst_n = 1'b0; in_valid = 1'b0; op = '0; word = 1'b0;
    operand = '0; shamt = '0; out_ready = 1'b1;

    // Reset state
    step(); step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", result, 64'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Main ops
    run_op("sra", 2'b10, 1'b0, 64'h8000_0000_0000_0000, 6'd4,  64'hF800_0000_0000_0000);
    run_op("sll63", 2'b00, 1'b0, 64'h1, 6'd63, 64'h8000_0000_0000_0000);
    run_op("sll8", 2'b00, 1'b0, 64'h0123_4567_89AB_CDEF, 6'd8, 64'h2345_6789_ABCD_EF00);
    run_op("srlw", 2'b01, 1'b1, 64'hFFFF_FFFF_8000_0000, 6'h21, 64'h0000_0000_4000_0000);
    run_op("sraw", 2'b10, 1'b1, 64'hFFFF_FFFF_8000_0000, 6'h21, 64'hFFFF_FFFF_C000_0000);
    run_op("sllw", 2'b00, 1'b1, 64'h1, 6'd31, 64'hFFFF_FFFF_8000_0000);
    run_op("srl63", 2'b01, 1'b0, 64'h8000_0000_0000_0000, 6'd63, 64'h1);

    // Backpressure with a competing request held on the input
    out_ready = 1'b0;
    wait_ready();
    in_valid = 1'b1; op = 2'b01; word = 1'b0; operand = 64'h100; shamt = 6'd4;
    step();
    operand = 64'hF0; shamt = 6'd4;
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'd6);
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_hold_result", result, 64'h10);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_idle_ready", 64'(in_ready), 64'd1);
    check("bp_idle_busy", 64'(busy), 64'd0);
    check("bp_idle_result", result, 64'd0);
    step();
    in_valid = 1'b0;
    check("bp_second_taken", 64'(busy), 64'd1);
    wait_valid(lat);
    check("bp_second_latency", 64'(lat), 64'd6);
    check("bp_second_result", result, 64'hF);
    step();

    // Reset in the middle of an operation (counter == 3)
    wait_ready();
    in_valid = 1'b1; op = 2'b10; word = 1'b0; operand = 64'hFFFF_0000_0000_0000; shamt = 6'd63;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_result", result, 64'd0);
    rst_n = 1'b1;
    step();
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_no_result", 64'(out_valid), 64'd0);
    run_op("after_rst", 2'b01, 1'b0, 64'hF0, 6'd4, 64'hF);

    // Zero shift and reserved op
    run_op("zero_sra", 2'b10, 1'b0, 64'hDEAD_BEEF_0000_0001, 6'd0, 64'hDEAD_BEEF_0000_0001);
    run_op("rsv_op", 2'b11, 1'b0, 64'h0123_4567_89AB_CDEF, 6'd13, 64'h0123_4567_89AB_CDEF);

    // Back-to-back with out_ready tied high: one accept every 8 cycles
    nacc = 0;
    in_valid = 1'b1; op = 2'b01; word = 1'b0; operand = 64'h80; shamt = 6'd1;
    for (int c = 0; c < 25; c++) begin
      if (in_ready && nacc < 3) begin acc[nacc] = c; nacc++; end
      if (out_valid) check("b2b_result", result, 64'h40);
      step();
    end
    in_valid = 1'b0;
    check("b2b_accepts", 64'(nacc), 64'd3);
    check("b2b_gap1", 64'(acc[1] - acc[0]), 64'd8);
    check("b2b_gap2", 64'(acc[2] - acc[1]), 64'd8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
